// File: rtl/hls_handshake_profiler.sv
// rtl/hls_handshake_profiler.sv - per-channel ap_ctrl_chain handshake profiler with event FIFO
module hls_handshake_profiler #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 32,
    parameter int LAT_W      = 24,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] mon_start,
    input  logic [NUM_CH-1:0] mon_ready,
    input  logic [NUM_CH-1:0] mon_done,
    input  logic [NUM_CH-1:0] mon_continue,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CH_W-1:0]   ev_ch,
    output logic [LAT_W-1:0]  ev_lat,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DWAIT = 2'd2;

    logic [1:0]       state     [NUM_CH];
    logic [LAT_W-1:0] lat       [NUM_CH];
    logic [CNT_W-1:0] start_cnt [NUM_CH];
    logic [CNT_W-1:0] done_cnt  [NUM_CH];
    logic [CNT_W-1:0] busy_cnt  [NUM_CH];
    logic [CNT_W-1:0] stall_cnt [NUM_CH];
    logic [CNT_W-1:0] ready_cnt [NUM_CH];
    logic [CNT_W-1:0] lat_sum   [NUM_CH];
    logic [LAT_W-1:0] min_lat   [NUM_CH];
    logic [LAT_W-1:0] max_lat   [NUM_CH];
    logic [NUM_CH-1:0] pend_v;
    logic [LAT_W-1:0] pend_lat  [NUM_CH];

    logic [CH_W-1:0]  fifo_ch   [FIFO_DEPTH];
    logic [LAT_W-1:0] fifo_lat  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    logic [1:0]        state_n [NUM_CH];
    logic [LAT_W-1:0]  lat_n   [NUM_CH];
    logic [LAT_W-1:0]  rec_lat [NUM_CH];
    logic [LAT_W-1:0]  lat_p1;
    logic [NUM_CH-1:0] rec, inc_start, inc_done, inc_busy, inc_stall, inc_ready;
    logic              push_found, push, pop, fifo_full;
    logic [CH_W-1:0]   push_idx;
    logic [4:0]        drops;
    logic [CNT_W-1:0]  rd_mux;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Latency counts the start cycle through the done cycle inclusive.
    always_comb begin
        lat_p1    = '0;
        rec       = '0;
        inc_start = '0;
        inc_done  = '0;
        inc_busy  = '0;
        inc_stall = '0;
        inc_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_n[c] = state[c];
            lat_n[c]   = lat[c];
            rec_lat[c] = '0;
            lat_p1     = (&lat[c]) ? lat[c] : lat[c] + 1'b1;
            if (enable) begin
                inc_ready[c] = mon_ready[c] && (state[c] != S_DWAIT);
                case (state[c])
                    S_IDLE: if (mon_start[c]) begin
                        inc_start[c] = 1'b1;
                        lat_n[c]     = LAT_W'(1);
                        if (mon_done[c]) begin
                            rec[c]       = 1'b1;
                            rec_lat[c]   = LAT_W'(1);
                            inc_done[c]  = mon_continue[c];
                            state_n[c]   = mon_continue[c] ? S_IDLE : S_DWAIT;
                        end else begin
                            state_n[c]   = S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        inc_busy[c] = 1'b1;
                        lat_n[c]    = lat_p1;
                        if (mon_done[c]) begin
                            rec[c]      = 1'b1;
                            rec_lat[c]  = lat_p1;
                            inc_done[c] = mon_continue[c];
                            state_n[c]  = mon_continue[c] ? S_IDLE : S_DWAIT;
                        end
                    end
                    S_DWAIT: begin
                        inc_stall[c] = 1'b1;
                        if (mon_continue[c]) begin
                            inc_done[c] = 1'b1;
                            state_n[c]  = S_IDLE;
                        end
                    end
                    default: state_n[c] = S_IDLE;
                endcase
            end
        end
    end

    assign ev_valid  = (count != '0);
    assign ev_ch     = ev_valid ? fifo_ch[rd_ptr]  : '0;
    assign ev_lat    = ev_valid ? fifo_lat[rd_ptr] : '0;
    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = ev_valid && ev_ready;
    assign push      = push_found && (!fifo_full || pop);

    // A slot being pushed this cycle is free for a same-cycle record on its channel.
    always_comb begin
        push_found = 1'b0;
        push_idx   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend_v[c]) begin
                push_found = 1'b1;
                push_idx   = CH_W'(c);
            end
        end
        drops = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rec[c] && pend_v[c] && !(push && push_idx == CH_W'(c)))
                drops = drops + 5'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                3'd0: rd_mux = start_cnt[rd_ch];
                3'd1: rd_mux = done_cnt[rd_ch];
                3'd2: rd_mux = busy_cnt[rd_ch];
                3'd3: rd_mux = stall_cnt[rd_ch];
                3'd4: rd_mux = ready_cnt[rd_ch];
                3'd5: rd_mux = CNT_W'(min_lat[rd_ch]);
                3'd6: rd_mux = CNT_W'(max_lat[rd_ch]);
                default: rd_mux = lat_sum[rd_ch];
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!ap_rst_n) state[c] <= S_IDLE;
                lat[c]       <= ap_rst_n ? LAT_W'(1) : '0;
                start_cnt[c] <= '0;
                done_cnt[c]  <= '0;
                busy_cnt[c]  <= '0;
                stall_cnt[c] <= '0;
                ready_cnt[c] <= '0;
                lat_sum[c]   <= '0;
                min_lat[c]   <= '1;
                max_lat[c]   <= '0;
                pend_lat[c]  <= '0;
            end
            pend_v   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            rd_data  <= '0;
        end else begin
            rd_data  <= rd_mux;
            drop_cnt <= sat_add(drop_cnt, CNT_W'(drops));
            if (push) begin
                fifo_ch[wr_ptr]  <= push_idx;
                fifo_lat[wr_ptr] <= pend_lat[push_idx];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rec[c] && (!pend_v[c] || (push && push_idx == CH_W'(c)))) begin
                    pend_v[c]   <= 1'b1;
                    pend_lat[c] <= rec_lat[c];
                end else if (push && push_idx == CH_W'(c)) begin
                    pend_v[c]   <= 1'b0;
                end
                state[c] <= state_n[c];
                lat[c]   <= lat_n[c];
                if (inc_start[c]) start_cnt[c] <= sat_inc(start_cnt[c]);
                if (inc_done[c])  done_cnt[c]  <= sat_inc(done_cnt[c]);
                if (inc_busy[c])  busy_cnt[c]  <= sat_inc(busy_cnt[c]);
                if (inc_stall[c]) stall_cnt[c] <= sat_inc(stall_cnt[c]);
                if (inc_ready[c]) ready_cnt[c] <= sat_inc(ready_cnt[c]);
                if (rec[c]) begin
                    if (rec_lat[c] < min_lat[c]) min_lat[c] <= rec_lat[c];
                    if (rec_lat[c] > max_lat[c]) max_lat[c] <= rec_lat[c];
                    lat_sum[c] <= sat_add(lat_sum[c], CNT_W'(rec_lat[c]));
                end
            end
        end
    end
endmodule

// File: tb/tb_hls_handshake_profiler.sv
// tb/tb_hls_handshake_profiler.sv - scoreboard bench for hls_handshake_profiler
module tb_hls_handshake_profiler;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam longint LAT_MAX = (longint'(1) << 24) - 1;
    localparam longint CNT_MAX = (longint'(1) << 32) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAITC = 2;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n, enable, clear, ev_ready, ev_valid;
    logic [1:0]  mon_start, mon_ready, mon_done, mon_continue;
    logic [0:0]  rd_ch, ev_ch;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data, drop_cnt;
    logic [23:0] ev_lat;

    always #5 ap_clk = ~ap_clk;

    hls_handshake_profiler #(.NUM_CH(2), .CNT_W(32), .LAT_W(24), .FIFO_DEPTH(8)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .clear(clear),
        .mon_start(mon_start), .mon_ready(mon_ready), .mon_done(mon_done),
        .mon_continue(mon_continue), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_lat(ev_lat),
        .drop_cnt(drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {int ch; longint lat;} ev_t;
    ev_t exp_q[$];
    ev_t got_q[$];

    int     m_st   [NUM_CH];
    longint m_lat  [NUM_CH];
    longint m_stat [NUM_CH][8];
    bit     m_pv   [NUM_CH];
    longint m_pl   [NUM_CH];
    int     m_occ;
    longint m_drop;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 8; s++) m_stat[c][s] = 0;
            m_stat[c][5] = LAT_MAX;
            m_pv[c] = 0;
        end
        m_occ  = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic m_inc(input int c, input int s);
        m_stat[c][s] = sat(m_stat[c][s] + 1, CNT_MAX);
    endtask

    // A completed transaction: statistics always, record only if the slot is free.
    task automatic m_finish(input int c);
        longint l;
        l = m_lat[c];
        if (l < m_stat[c][5]) m_stat[c][5] = l;
        if (l > m_stat[c][6]) m_stat[c][6] = l;
        m_stat[c][7] = sat(m_stat[c][7] + l, CNT_MAX);
        if (m_pv[c]) m_drop = sat(m_drop + 1, CNT_MAX);
        else begin m_pv[c] = 1; m_pl[c] = l; end
        if (mon_continue[c]) begin m_inc(c, 1); m_st[c] = M_IDLE; end
        else m_st[c] = M_WAITC;
    endtask

    always @(posedge ap_clk) begin : model
        int pc;
        bit pop;
        ev_t e;
        if (ap_rst_n !== 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin m_st[c] = M_IDLE; m_lat[c] = 0; end
            m_clear();
        end else if (clear) begin
            m_clear();
            for (int c = 0; c < NUM_CH; c++) m_lat[c] = 1;
        end else begin
            pop = (m_occ > 0) && ev_ready;
            pc = -1;
            for (int c = 0; c < NUM_CH; c++) if (m_pv[c] && pc < 0) pc = c;
            if (pc >= 0 && (m_occ < DEPTH || pop)) begin
                e.ch = pc; e.lat = m_pl[pc];
                exp_q.push_back(e);
                m_pv[pc] = 0;
                m_occ++;
            end
            if (pop) m_occ--;
            if (enable) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mon_ready[c] && m_st[c] != M_WAITC) m_inc(c, 4);
                    case (m_st[c])
                        M_IDLE: if (mon_start[c]) begin
                            m_inc(c, 0);
                            m_lat[c] = 1;
                            if (mon_done[c]) m_finish(c);
                            else m_st[c] = M_RUN;
                        end
                        M_RUN: begin
                            m_inc(c, 2);
                            m_lat[c] = sat(m_lat[c] + 1, LAT_MAX);
                            if (mon_done[c]) m_finish(c);
                        end
                        default: begin
                            m_inc(c, 3);
                            if (mon_continue[c]) begin m_inc(c, 1); m_st[c] = M_IDLE; end
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge ap_clk) begin : monitor
        ev_t e;
        ev_t g;
        if (ap_rst_n === 1'b1) begin
            check("ev_valid", ev_valid, exp_q.size() != 0);
            if (ev_valid && ev_ready && !clear && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.ch = int'(ev_ch); g.lat = longint'(ev_lat);
                got_q.push_back(g);
                check("ev_ch", g.ch, e.ch);
                check("ev_lat", g.lat, e.lat);
            end
        end
    end

    function automatic longint got_lat(input int i);
        return (i < got_q.size()) ? got_q[i].lat : -1;
    endfunction

    function automatic longint got_ch(input int i);
        return (i < got_q.size()) ? longint'(got_q[i].ch) : -1;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic rd(input int ch, input int sel, output longint v);
        rd_ch  = ch[0:0];
        rd_sel = sel[2:0];
        tick();
        v = longint'(rd_data);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        longint v;
        for (int s = 0; s < 8; s++) begin
            rd(0, s, v);
            check($sformatf("%s_sel%0d", tag, s), v, (s == 5) ? 64'hFFFFFF : 0);
        end
        check({tag, "_ev_valid"}, ev_valid, 0);
        check({tag, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        longint v;
        longint exp1 [8];
        ap_rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ev_ready = 1'b0;
        mon_start = '0; mon_ready = '0; mon_done = '0; mon_continue = '0;
        rd_ch = '0; rd_sel = '0;
        repeat (3) tick();
        check("rst_rd_data", rd_data, 0);
        check("rst_ev_ch", ev_ch, 0);
        check("rst_ev_lat", ev_lat, 0);
        ap_rst_n = 1'b1;
        check_cleared("rst");

        // start, done+continue five cycles later
        enable = 1'b1; ev_ready = 1'b1; mon_continue = 2'b11; got_q.delete();
        mon_start = 2'b01; tick(); mon_start = '0;
        repeat (4) tick();
        mon_done = 2'b01; tick(); mon_done = '0;
        repeat (5) tick();
        enable = 1'b0;
        check("d1_events", got_q.size(), 1);
        check("d1_ch", got_ch(0), 0);
        check("d1_lat", got_lat(0), 6);
        exp1 = '{1, 1, 5, 0, 0, 6, 6, 6};
        for (int s = 0; s < 8; s++) begin
            rd(0, s, v);
            check($sformatf("d1_sel%0d", s), v, exp1[s]);
        end
        do_clear();
        check_cleared("clr");

        // ch1 held in DWAIT by continue=0
        enable = 1'b1; got_q.delete(); mon_continue = 2'b01;
        mon_start = 2'b10; tick(); mon_start = '0;
        tick();
        mon_done = 2'b10; tick(); mon_done = '0;
        repeat (3) tick();
        mon_continue = 2'b11; tick();
        repeat (4) tick();
        enable = 1'b0;
        rd(1, 3, v); check("dw_stall", v, 4);
        rd(1, 1, v); check("dw_done", v, 1);
        check("dw_lat", got_lat(0), 3);

        // simultaneous completions on ch0 (lat 3) and ch1 (lat 7)
        do_clear(); enable = 1'b1; got_q.delete();
        mon_start = 2'b10; tick(); mon_start = '0;
        repeat (3) tick();
        mon_start = 2'b01; tick(); mon_start = '0;
        tick();
        mon_done = 2'b11; tick(); mon_done = '0;
        repeat (5) tick();
        check("sim_ch0", got_ch(0), 0);
        check("sim_lat0", got_lat(0), 3);
        check("sim_ch1", got_ch(1), 1);
        check("sim_lat1", got_lat(1), 7);

        // ten completions with the consumer stalled
        do_clear(); ev_ready = 1'b0; got_q.delete();
        for (int i = 0; i < 10; i++) begin
            mon_start = 2'b01; mon_done = 2'b01; tick();
            mon_start = '0; mon_done = '0; tick();
        end
        repeat (3) tick();
        check("full_drop", drop_cnt, 1);
        ev_ready = 1'b1;
        repeat (15) tick();
        check("full_drained", got_q.size(), 9);

        // enable=0 freezes a busy channel mid-flight
        do_clear(); got_q.delete(); enable = 1'b1;
        mon_start = 2'b01; tick(); mon_start = '0;
        repeat (3) tick();
        enable = 1'b0;
        repeat (20) tick();
        rd(0, 2, v); check("frz_busy", v, 3);
        enable = 1'b1;
        mon_done = 2'b01; tick(); mon_done = '0;
        repeat (4) tick();
        check("frz_lat", got_lat(0), 5);
        rd(0, 2, v); check("frz_busy_after", v, 4);

        // randomized traffic against the reference model
        do_clear();
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                mon_start[c]    = ($urandom_range(0, 2) == 0);
                mon_done[c]     = ($urandom_range(0, 3) == 0);
                mon_continue[c] = ($urandom_range(0, 3) != 0);
                mon_ready[c]    = $urandom_range(0, 1);
            end
            ev_ready = ((i / 200) % 2 != 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            rd_ch  = 1'($urandom_range(0, 1));
            rd_sel = 3'($urandom_range(0, 7));
            tick();
        end
        clear = 1'b0; enable = 1'b0; mon_ready = '0;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 8; s++) begin
                rd(c, s, v);
                check($sformatf("rnd_ch%0d_sel%0d", c, s), v, m_stat[c][s]);
            end
        end
        check("rnd_drop", drop_cnt, m_drop);
        ev_ready = 1'b1;
        repeat (20) tick();
        check("rnd_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
